dcpu_sram_bridge: RTL and testbench

//  Bus slave sitting directly downstream of the dcpu core. Accepts one 16-bit core bus cycle at a time
//  (cyc/stb[1:0]/we/addr/dat -> ack/dat) and runs it on an external 8-bit asynchronous SRAM.

---
 rtl/dcpu_bus_pkg.sv | 17 +
 rtl/sram_byte_cycle.sv | 86 ++++++++
 rtl/dcpu_sram_bridge.sv | 136 +++++++++++++
 tb/tb_dcpu_sram_bridge.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dcpu_bus_pkg.sv
// Shared constants for the dcpu core bus and the SRAM bridge: widths, lane indices and
// bridge state encodings.
package dcpu_bus_pkg;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 16;

  localparam logic LANE_LO = 1'b0;
  localparam logic LANE_HI = 1'b1;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_SETUP  = 3'd1;
  localparam logic [2:0] ST_STROBE = 3'd2;
  localparam logic [2:0] ST_HOLD   = 3'd3;
  localparam logic [2:0] ST_ACK    = 3'd4;

endpackage

// File: rtl/sram_byte_cycle.sv
// Runs one SETUP/STROBE/HOLD byte access on the asynchronous SRAM and owns the wait counter.
// A start seen in HOLD chains straight into the next SETUP.
module sram_byte_cycle
  import dcpu_bus_pkg::*;
#(
  parameter int unsigned AW          = 16,
  parameter int unsigned WAIT_CYCLES = 1
) (
  input  logic          i_clk,
  input  logic          i_reset_n,
  input  logic          i_start,
  input  logic          i_we,
  input  logic [AW-1:0] i_addr,
  input  logic [7:0]    i_wdat,
  output logic          o_done,
  output logic [7:0]    o_rdat,
  output logic [AW-1:0] o_sram_addr,
  output logic [7:0]    o_sram_dat,
  output logic          o_sram_dat_oe,
  input  logic [7:0]    i_sram_dat,
  output logic          o_sram_ce_n,
  output logic          o_sram_oe_n,
  output logic          o_sram_we_n
);

  localparam logic [3:0] WaitLoad = 4'(WAIT_CYCLES - 1);

  logic [2:0]    state_q, state_d;
  logic [3:0]    cnt_q;
  logic          we_q;
  logic [AW-1:0] addr_q;
  logic [7:0]    wdat_q, rdat_q;

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_SETUP:  state_d = ST_STROBE;
      ST_STROBE: if (cnt_q == 4'd0) state_d = ST_HOLD;
      default:   state_d = i_start ? ST_SETUP : ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdat_q  <= '0;
      rdat_q  <= '0;
    end else begin
      state_q <= state_d;
      case (state_q)
        ST_SETUP:  cnt_q <= WaitLoad;
        ST_STROBE: begin
          if (cnt_q != 4'd0) begin
            cnt_q <= cnt_q - 4'd1;
          end else if (!we_q) begin
            rdat_q <= i_sram_dat;
          end
        end
        default: begin
          if (i_start) begin
            we_q   <= i_we;
            addr_q <= i_addr;
            wdat_q <= i_wdat;
          end
        end
      endcase
    end
  end

  logic active, drive_phase;
  assign active      = (state_q != ST_IDLE);
  assign drive_phase = (state_q == ST_SETUP) || (state_q == ST_STROBE);

  assign o_done        = (state_q == ST_HOLD);
  assign o_rdat        = rdat_q;
  assign o_sram_addr   = addr_q;
  assign o_sram_dat    = wdat_q;
  assign o_sram_dat_oe = we_q && active;
  assign o_sram_ce_n   = !active;
  assign o_sram_oe_n   = !(!we_q && drive_phase);
  assign o_sram_we_n   = !(we_q && (state_q == ST_STROBE));

endmodule

// File: rtl/dcpu_sram_bridge.sv
// dcpu core bus slave running each enabled byte lane as one 8-bit SRAM cycle.
// Define MEM_BRIDGE_ROM_WP_EN to silently drop writes below ROM_BYTES.
module dcpu_sram_bridge
  import dcpu_bus_pkg::*;
#(
  parameter int unsigned SRAM_AW     = 16,
  parameter int unsigned WAIT_CYCLES = 1,
  parameter int unsigned ROM_BYTES   = 32'h1000
) (
  input  logic               i_clk,
  input  logic               i_reset_n,
  input  logic               i_cyc,
  input  logic [1:0]         i_stb,
  input  logic               i_we,
  input  logic [ADDR_W-1:0]  i_addr,
  input  logic [DATA_W-1:0]  i_dat,
  output logic [DATA_W-1:0]  o_dat,
  output logic               o_ack,
  output logic [SRAM_AW-1:0] o_sram_addr,
  output logic [7:0]         o_sram_dat,
  output logic               o_sram_dat_oe,
  input  logic [7:0]         i_sram_dat,
  output logic               o_sram_ce_n,
  output logic               o_sram_oe_n,
  output logic               o_sram_we_n
);

  // Top-level states: ST_SETUP here means "lane(s) in flight in the byte engine".
  logic [2:0]         state_q;
  logic [SRAM_AW-1:1] addr_q;
  logic [DATA_W-1:0]  wdat_q, rdat_q;
  logic               we_q, lane_q;
  logic [1:0]         stb_q;
  logic [7:0]         lo_q;

  logic               bc_start, bc_done, bc_we, bc_lane;
  logic [SRAM_AW-1:1] bc_base;
  logic [DATA_W-1:0]  bc_word;
  logic [7:0]         bc_rdat;
  logic               bc_ce_n, bc_we_n, bc_dat_oe;

  logic req, next_hi, unused_addr;
  assign req     = (state_q == ST_IDLE) && i_cyc && (|i_stb);
  assign next_hi = (state_q == ST_SETUP) && bc_done && (lane_q == LANE_LO) && stb_q[1];
  assign unused_addr = ^{i_addr[ADDR_W-1:SRAM_AW], i_addr[0]};

  always_comb begin
    bc_start = req || next_hi;
    bc_lane  = LANE_HI;
    bc_base  = addr_q;
    bc_we    = we_q;
    bc_word  = wdat_q;
    if (req) begin
      bc_lane = i_stb[0] ? LANE_LO : LANE_HI;
      bc_base = i_addr[SRAM_AW-1:1];
      bc_we   = i_we;
      bc_word = i_dat;
    end
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      wdat_q  <= '0;
      rdat_q  <= '0;
      we_q    <= 1'b0;
      lane_q  <= LANE_LO;
      stb_q   <= '0;
      lo_q    <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (req) begin
            addr_q  <= i_addr[SRAM_AW-1:1];
            wdat_q  <= i_dat;
            we_q    <= i_we;
            stb_q   <= i_stb;
            lane_q  <= bc_lane;
            state_q <= ST_SETUP;
          end
        end
        ST_SETUP: begin
          if (bc_done) begin
            if (lane_q == LANE_LO) lo_q <= bc_rdat;
            if (next_hi) begin
              lane_q <= LANE_HI;
            end else begin
              state_q <= ST_ACK;
              if (!we_q) begin
                rdat_q <= {stb_q[1] ? bc_rdat : 8'h00,
                           !stb_q[0] ? 8'h00 : ((lane_q == LANE_LO) ? bc_rdat : lo_q)};
              end
            end
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  sram_byte_cycle #(
    .AW          (SRAM_AW),
    .WAIT_CYCLES (WAIT_CYCLES)
  ) u_byte (
    .i_clk         (i_clk),
    .i_reset_n     (i_reset_n),
    .i_start       (bc_start),
    .i_we          (bc_we),
    .i_addr        ({bc_base, bc_lane}),
    .i_wdat        (bc_lane ? bc_word[15:8] : bc_word[7:0]),
    .o_done        (bc_done),
    .o_rdat        (bc_rdat),
    .o_sram_addr   (o_sram_addr),
    .o_sram_dat    (o_sram_dat),
    .o_sram_dat_oe (bc_dat_oe),
    .i_sram_dat    (i_sram_dat),
    .o_sram_ce_n   (bc_ce_n),
    .o_sram_oe_n   (o_sram_oe_n),
    .o_sram_we_n   (bc_we_n)
  );

  logic wp_drop;
`ifdef MEM_BRIDGE_ROM_WP_EN
  assign wp_drop = we_q && (32'(o_sram_addr) < ROM_BYTES);
`else
  assign wp_drop = 1'b0;
`endif

  assign o_sram_ce_n   = bc_ce_n || wp_drop;
  assign o_sram_we_n   = bc_we_n || wp_drop;
  assign o_sram_dat_oe = bc_dat_oe && !wp_drop;
  assign o_dat         = rdat_q;
  assign o_ack         = (state_q == ST_ACK) && i_cyc;

endmodule

// File: tb/tb_dcpu_sram_bridge.sv
// Directed bench for dcpu_sram_bridge: byte-wide SRAM model, latency/pulse monitors and a
// second instance with WAIT_CYCLES = 3.
module tb_dcpu_sram_bridge;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cyc, we;
  logic [1:0]  stb;
  logic [31:0] addr;
  logic [15:0] dat;
  logic [15:0] rdat;
  logic        ack, s_oe, ce_n, oe_n, we_n;
  logic [15:0] s_addr;
  logic [7:0]  s_dat, s_rdat;

  logic        cyc3, we3;
  logic [1:0]  stb3;
  logic [31:0] addr3;
  logic [15:0] dat3, rdat3;
  logic        ack3, s_oe3, ce_n3, oe_n3, we_n3;
  logic [15:0] s_addr3;
  logic [7:0]  s_dat3, s_rdat3;

  always #5 clk = ~clk;

  dcpu_sram_bridge #(.SRAM_AW(16), .WAIT_CYCLES(1), .ROM_BYTES(32'h1000)) dut (
    .i_clk(clk), .i_reset_n(rst_n), .i_cyc(cyc), .i_stb(stb), .i_we(we), .i_addr(addr),
    .i_dat(dat), .o_dat(rdat), .o_ack(ack), .o_sram_addr(s_addr), .o_sram_dat(s_dat),
    .o_sram_dat_oe(s_oe), .i_sram_dat(s_rdat), .o_sram_ce_n(ce_n), .o_sram_oe_n(oe_n),
    .o_sram_we_n(we_n)
  );

  dcpu_sram_bridge #(.SRAM_AW(16), .WAIT_CYCLES(3), .ROM_BYTES(32'h1000)) dut3 (
    .i_clk(clk), .i_reset_n(rst_n), .i_cyc(cyc3), .i_stb(stb3), .i_we(we3), .i_addr(addr3),
    .i_dat(dat3), .o_dat(rdat3), .o_ack(ack3), .o_sram_addr(s_addr3), .o_sram_dat(s_dat3),
    .o_sram_dat_oe(s_oe3), .i_sram_dat(s_rdat3), .o_sram_ce_n(ce_n3), .o_sram_oe_n(oe_n3),
    .o_sram_we_n(we_n3)
  );

  // SRAM model; preloads go through pl_* so only this block writes mem
  logic [7:0]  mem [0:65535];
  logic        pl_en = 1'b0;
  logic [15:0] pl_addr = '0;
  logic [7:0]  pl_dat = '0;
  always @(posedge clk) begin
    if (pl_en) mem[pl_addr] <= pl_dat;
    else if (!ce_n && !we_n && s_oe) mem[s_addr] <= s_dat;
  end
  assign s_rdat  = (!ce_n && !oe_n) ? mem[s_addr] : 8'hEE;
  assign s_rdat3 = (!ce_n3 && !oe_n3) ? (s_addr3[7:0] ^ 8'hA5) : 8'hEE;

  int cyc_cnt = 0, oe_pulses = 0, we_pulses = 0, ce_pulses = 0, ack_cnt = 0;
  logic [15:0] oe_addr_prev = '0, oe_addr_last = '0, we_addr_last = '0;
  logic [7:0]  we_dat_last = '0;
  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;
  always @(negedge clk) if (ack) ack_cnt <= ack_cnt + 1;
  always @(negedge ce_n) ce_pulses <= ce_pulses + 1;
  always @(negedge oe_n) begin
    #1;
    oe_addr_prev <= oe_addr_last;
    oe_addr_last <= s_addr;
    oe_pulses    <= oe_pulses + 1;
  end
  always @(negedge we_n) begin
    #1;
    we_addr_last <= s_addr;
    we_dat_last  <= s_dat;
    we_pulses    <= we_pulses + 1;
  end

  int n_cmp = 0, n_bad = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic preload(input logic [15:0] a, input logic [7:0] d);
    @(negedge clk);
    pl_addr = a;
    pl_dat  = d;
    pl_en   = 1'b1;
    @(negedge clk);
    pl_en = 1'b0;
  endtask

  // Request is sampled at the end of cycle t0; lat = ack cycle - t0, 999 on timeout.
  task automatic xfer(input logic [31:0] a, input logic w, input logic [1:0] s,
                      input logic [15:0] d, output logic [15:0] rd, output int lat);
    int t0;
    @(posedge clk); #1;
    cyc = 1'b1; stb = s; we = w; addr = a; dat = d;
    t0 = cyc_cnt;
    @(posedge clk); #1;
    addr = ~a; dat = ~d; we = ~w;
    lat = 999;
    rd  = '0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (ack) begin
        lat = cyc_cnt - t0;
        rd  = rdat;
        break;
      end
    end
  endtask

  task automatic go_idle(input int n);
    @(posedge clk); #1;
    cyc = 1'b0; stb = 2'b00; we = 1'b0;
    repeat (n) @(posedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  logic [15:0] rd;
  int lat, a0, p0, c0;

  initial begin
    rst_n = 1'b0;
    cyc = 0; stb = 0; we = 0; addr = 0; dat = 0;
    cyc3 = 0; stb3 = 0; we3 = 0; addr3 = 0; dat3 = 0;
    repeat (3) @(posedge clk);
    #1;
    check_eq("reset ce_n", ce_n, 1);
    check_eq("reset oe_n", oe_n, 1);
    check_eq("reset we_n", we_n, 1);
    check_eq("reset dat_oe", s_oe, 0);
    check_eq("reset ack", ack, 0);
    check_eq("reset o_dat", rdat, 0);
    check_eq("reset sram_addr", s_addr, 0);
    @(negedge clk) rst_n = 1'b1;

    // word read
    preload(16'h0000, 8'h34);
    preload(16'h0001, 8'h12);
    a0 = ack_cnt; p0 = oe_pulses;
    xfer(32'h0, 1'b0, 2'b11, 16'h0, rd, lat);
    go_idle(3);
    check_eq("word read data", rd, 16'h1234);
    check_eq("word read latency", lat, 7);
    check_eq("word read oe pulses", oe_pulses - p0, 2);
    check_eq("word read ack count", ack_cnt - a0, 1);

    // high-byte write
    preload(16'h0010, 8'h5A);
    preload(16'h0011, 8'h00);
    p0 = we_pulses;
    xfer(32'h10, 1'b1, 2'b10, 16'hAB00, rd, lat);
    go_idle(2);
    check_eq("hi write latency", lat, 4);
    check_eq("hi write we pulses", we_pulses - p0, 1);
    check_eq("hi write sram addr", we_addr_last, 16'h0011);
    check_eq("hi write sram dat", we_dat_last, 8'hAB);
    check_eq("hi write mem 0x11", mem[16'h0011], 8'hAB);
    check_eq("hi write mem 0x10", mem[16'h0010], 8'h5A);
    check_eq("o_dat held after write", rdat, 16'h1234);

    // back-to-back fetches
    preload(16'h0002, 8'h78);
    preload(16'h0003, 8'h56);
    preload(16'h0004, 8'hBC);
    preload(16'h0005, 8'h9A);
    xfer(32'h0, 1'b0, 2'b11, 16'h0, rd, lat);
    check_eq("fetch0 data", rd, 16'h1234);
    check_eq("fetch0 latency", lat, 7);
    xfer(32'h2, 1'b0, 2'b11, 16'h0, rd, lat);
    check_eq("fetch1 data", rd, 16'h5678);
    check_eq("fetch1 latency", lat, 7);
    xfer(32'h4, 1'b0, 2'b11, 16'h0, rd, lat);
    check_eq("fetch2 data", rd, 16'h9ABC);
    check_eq("fetch2 latency", lat, 7);

    // single-lane reads zero the other lane
    xfer(32'h2, 1'b0, 2'b01, 16'h0, rd, lat);
    check_eq("lo byte read data", rd, 16'h0078);
    check_eq("lo byte read latency", lat, 4);
    xfer(32'h2, 1'b0, 2'b10, 16'h0, rd, lat);
    check_eq("hi byte read data", rd, 16'h5600);
    check_eq("hi byte read latency", lat, 4);
    go_idle(2);

    // cyc with no strobes is ignored
    @(posedge clk); #1;
    cyc = 1'b1; stb = 2'b00; addr = 32'h0;
    a0 = ack_cnt; c0 = ce_pulses;
    repeat (6) @(posedge clk);
    check_eq("stb0 no ce", ce_pulses - c0, 0);
    check_eq("stb0 no ack", ack_cnt - a0, 0);
    go_idle(1);

    // cyc dropped mid-write: SRAM sequence completes, ack suppressed
    preload(16'h0020, 8'h00);
    preload(16'h0021, 8'h00);
    a0 = ack_cnt; p0 = we_pulses;
    @(posedge clk); #1;
    cyc = 1'b1; stb = 2'b11; we = 1'b1; addr = 32'h20; dat = 16'hCDEF;
    @(posedge clk); #1;
    @(posedge clk); #1;
    cyc = 1'b0; stb = 2'b00;
    repeat (10) @(posedge clk);
    check_eq("drop mem 0x20", mem[16'h0020], 8'hEF);
    check_eq("drop mem 0x21", mem[16'h0021], 8'hCD);
    check_eq("drop we pulses", we_pulses - p0, 2);
    check_eq("drop no ack", ack_cnt - a0, 0);
    go_idle(1);

    // reset during STROBE of a write
    preload(16'h0030, 8'h11);
    @(posedge clk); #1;
    cyc = 1'b1; stb = 2'b01; we = 1'b1; addr = 32'h30; dat = 16'h0077;
    @(posedge clk); #1;
    check_eq("rst setup dat_oe", s_oe, 1);
    @(posedge clk); #1;
    check_eq("rst strobe we_n", we_n, 0);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_eq("rst async we_n", we_n, 1);
    check_eq("rst async ce_n", ce_n, 1);
    check_eq("rst async dat_oe", s_oe, 0);
    check_eq("rst clears o_dat", rdat, 0);
    cyc = 1'b0; stb = 2'b00; we = 1'b0;
    a0 = ack_cnt;
    repeat (3) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    repeat (4) @(posedge clk);
    check_eq("rst no ack", ack_cnt - a0, 0);
    check_eq("rst mem untouched", mem[16'h0030], 8'h11);
    xfer(32'h30, 1'b0, 2'b01, 16'h0, rd, lat);
    check_eq("post-rst read data", rd, 16'h0011);
    check_eq("post-rst read latency", lat, 4);

    // address wrap above SRAM_AW
    xfer(32'h0001_0002, 1'b0, 2'b11, 16'h0, rd, lat);
    go_idle(1);
    check_eq("wrap data", rd, 16'h5678);
    check_eq("wrap first addr", oe_addr_prev, 16'h0002);
    check_eq("wrap second addr", oe_addr_last, 16'h0003);

    // WAIT_CYCLES = 3 instance
    @(posedge clk); #1;
    cyc3 = 1'b1; stb3 = 2'b11; we3 = 1'b0; addr3 = 32'h40;
    a0 = cyc_cnt;
    lat = 999;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (ack3) begin
        lat = cyc_cnt - a0;
        rd  = rdat3;
        break;
      end
    end
    check_eq("wait3 latency", lat, 11);
    check_eq("wait3 data", rd, 16'hE4E5);
    @(posedge clk); #1;
    cyc3 = 1'b0; stb3 = 2'b00;

    // write protection boundary
    preload(16'h0FFE, 8'hAA);
    preload(16'h0FFF, 8'hBB);
    preload(16'h1000, 8'h00);
    preload(16'h1001, 8'h00);
    p0 = we_pulses;
    xfer(32'h0FFE, 1'b1, 2'b11, 16'h1111, rd, lat);
    go_idle(2);
    check_eq("rom write latency", lat, 7);
`ifdef MEM_BRIDGE_ROM_WP_EN
    check_eq("rom write we pulses", we_pulses - p0, 0);
    check_eq("rom write mem 0xffe", mem[16'h0FFE], 8'hAA);
    check_eq("rom write mem 0xfff", mem[16'h0FFF], 8'hBB);
`else
    check_eq("rom write we pulses", we_pulses - p0, 2);
    check_eq("rom write mem 0xffe", mem[16'h0FFE], 8'h11);
    check_eq("rom write mem 0xfff", mem[16'h0FFF], 8'h11);
`endif
    p0 = we_pulses;
    xfer(32'h1000, 1'b1, 2'b11, 16'h2222, rd, lat);
    go_idle(2);
    check_eq("ram write latency", lat, 7);
    check_eq("ram write we pulses", we_pulses - p0, 2);
    check_eq("ram write mem 0x1000", mem[16'h1000], 8'h22);
    check_eq("ram write mem 0x1001", mem[16'h1001], 8'h22);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
